// File: rtl/arbiter_iwrr_burst_sched_if.sv
// Stream/arbitration bundle between the requester side and the burst scheduler.
// The scheduler connects through the slave modport; the requester/downstream
// environment drives the bundle through the master modport.
interface arbiter_iwrr_burst_sched_if #(
   parameter int P_REQUESTER_NUM = 4,
   parameter int P_WEIGHT_W      = 4,
   parameter int P_LEN_W         = 8
);
   localparam int IDX_W = $clog2(P_REQUESTER_NUM);

   logic [P_REQUESTER_NUM-1:0]            req_i;
   logic [P_REQUESTER_NUM*P_LEN_W-1:0]    req_len_i;
   logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] req_weight_i;
   logic [P_REQUESTER_NUM-1:0]            s_valid_i;
   logic [P_REQUESTER_NUM-1:0]            s_ready_o;
   logic                                  m_valid_o;
   logic                                  m_ready_i;
   logic                                  m_last_o;
   logic [P_REQUESTER_NUM-1:0]            grant_valid_o;
   logic [IDX_W-1:0]                      grant_idx_o;
   logic                                  busy_o;

   modport slave (
      input  req_i, req_len_i, req_weight_i, s_valid_i, m_ready_i,
      output s_ready_o, m_valid_o, m_last_o, grant_valid_o, grant_idx_o, busy_o
   );

   modport master (
      output req_i, req_len_i, req_weight_i, s_valid_i, m_ready_i,
      input  s_ready_o, m_valid_o, m_last_o, grant_valid_o, grant_idx_o, busy_o
   );
endinterface

// File: rtl/arbiter_iwrr_burst_sched.sv
// Burst-level interleaved weighted round-robin scheduler.
// One credit is spent per burst; the grant is locked until the last beat fires,
// and valid/ready are steered between the granted requester and the shared port.
// An idle cycle always separates consecutive bursts, which keeps the grant path
// purely registered (no combinational path from req_i to any output).
module arbiter_iwrr_burst_sched #(
   parameter int P_REQUESTER_NUM = 4,
   parameter int P_WEIGHT_W      = 4,
   parameter int P_LEN_W         = 8
) (
   input logic                       clk,
   input logic                       rst_n,
   arbiter_iwrr_burst_sched_if.slave bus
);
   localparam int N     = P_REQUESTER_NUM;
   localparam int IDX_W = $clog2(N);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   // Registered state
   logic [0:0]            state_r;
   logic [IDX_W-1:0]      ptr_r;
   logic [P_WEIGHT_W-1:0] credit_r [N];
   logic [P_LEN_W-1:0]    cnt_r;
   logic [N-1:0]          grant_valid_r;
   logic [IDX_W-1:0]      grant_idx_r;

   // Combinational helpers
   logic [N-1:0]          eligible_s;
   logic                  any_eligible_s;
   logic                  any_req_s;
   logic [IDX_W-1:0]      pick_idx_s;
   logic [N-1:0]          pick_onehot_s;
   logic [P_LEN_W-1:0]    pick_len_s;
   logic [IDX_W-1:0]      ptr_next_s;
   logic                  burst_s;
   logic                  m_valid_s;
   logic [N-1:0]          s_ready_s;
   logic                  m_last_s;
   logic                  fire_s;
   logic                  cnt_zero_s;

   assign any_req_s  = |bus.req_i;
   assign burst_s    = (state_r == S_BURST);
   assign cnt_zero_s = (cnt_r == {P_LEN_W{1'b0}});

   // A requester may compete only while it requests and still holds credit.
   always_comb begin
      eligible_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         eligible_s[i] = bus.req_i[i] & (credit_r[i] != {P_WEIGHT_W{1'b0}});
      end
   end

   // Cyclic search: first eligible index at/after ptr, otherwise lowest eligible.
   always_comb begin
      pick_idx_s     = {IDX_W{1'b0}};
      any_eligible_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any_eligible_s && eligible_s[i] && (i >= int'(ptr_r))) begin
            any_eligible_s = 1'b1;
            pick_idx_s     = IDX_W'(i);
         end else begin
            pick_idx_s     = pick_idx_s;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any_eligible_s && eligible_s[i]) begin
            any_eligible_s = 1'b1;
            pick_idx_s     = IDX_W'(i);
         end else begin
            pick_idx_s     = pick_idx_s;
         end
      end
   end

   // Decode the winner into a one-hot grant and select its burst length.
   always_comb begin
      pick_onehot_s = {N{1'b0}};
      pick_len_s    = {P_LEN_W{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (any_eligible_s && (pick_idx_s == IDX_W'(i))) begin
            pick_onehot_s[i] = 1'b1;
            pick_len_s       = bus.req_len_i[i*P_LEN_W +: P_LEN_W];
         end else begin
            pick_onehot_s[i] = 1'b0;
         end
      end
   end

   // Pointer moves just past the winner, wrapping explicitly for any N.
   always_comb begin
      if (pick_idx_s == IDX_W'(N - 1)) begin
         ptr_next_s = {IDX_W{1'b0}};
      end else begin
         ptr_next_s = pick_idx_s + IDX_W'(1);
      end
   end

   // Steer valid/ready between the granted requester and the shared port.
   always_comb begin
      if (burst_s) begin
         m_valid_s = |(bus.s_valid_i & grant_valid_r);
         s_ready_s = grant_valid_r & {N{bus.m_ready_i}};
         m_last_s  = cnt_zero_s;
      end else begin
         m_valid_s = 1'b0;
         s_ready_s = {N{1'b0}};
         m_last_s  = 1'b0;
      end
   end

   assign fire_s = m_valid_s & bus.m_ready_i;

   // Burst FSM: latch grant and length in IDLE, count beats down in BURST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_IDLE;
         ptr_r         <= {IDX_W{1'b0}};
         cnt_r         <= {P_LEN_W{1'b0}};
         grant_valid_r <= {N{1'b0}};
         grant_idx_r   <= {IDX_W{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (any_eligible_s) begin
                  state_r       <= S_BURST;
                  grant_valid_r <= pick_onehot_s;
                  grant_idx_r   <= pick_idx_s;
                  cnt_r         <= pick_len_s;
                  ptr_r         <= ptr_next_s;
               end else begin
                  state_r       <= S_IDLE;
               end
            end
            S_BURST: begin
               if (fire_s && cnt_zero_s) begin
                  state_r       <= S_IDLE;
                  grant_valid_r <= {N{1'b0}};
               end else if (fire_s) begin
                  cnt_r         <= cnt_r - P_LEN_W'(1);
               end else begin
                  cnt_r         <= cnt_r;
               end
            end
            default: begin
               state_r       <= S_IDLE;
               grant_valid_r <= {N{1'b0}};
               cnt_r         <= {P_LEN_W{1'b0}};
            end
         endcase
      end
   end

   // Credits: spend one on each grant, refill everyone when requesters are out of credit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            credit_r[i] <= {P_WEIGHT_W{1'b0}};
         end
      end else if ((state_r == S_IDLE) && any_eligible_s) begin
         for (int i = 0; i < N; i++) begin
            if (pick_onehot_s[i] && (credit_r[i] != {P_WEIGHT_W{1'b0}})) begin
               credit_r[i] <= credit_r[i] - P_WEIGHT_W'(1);
            end else begin
               credit_r[i] <= credit_r[i];
            end
         end
      end else if ((state_r == S_IDLE) && any_req_s) begin
         for (int i = 0; i < N; i++) begin
            credit_r[i] <= bus.req_weight_i[i*P_WEIGHT_W +: P_WEIGHT_W];
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            credit_r[i] <= credit_r[i];
         end
      end
   end

   assign bus.m_valid_o     = m_valid_s;
   assign bus.s_ready_o     = s_ready_s;
   assign bus.m_last_o      = m_last_s;
   assign bus.grant_valid_o = grant_valid_r;
   assign bus.grant_idx_o   = grant_idx_r;
   assign bus.busy_o        = burst_s;

endmodule

// File: tb/tb_arbiter_iwrr_burst_sched.sv
// Scoreboard bench for the burst scheduler: stimulus pushes expected beats
// (granted index, last flag) into a queue; a negedge monitor pops and compares
// on every shared-channel fire. Cycle-exact protocol points are checked inline.
module tb_arbiter_iwrr_burst_sched;
   localparam int N  = 4;
   localparam int WW = 4;
   localparam int LW = 8;

   typedef struct packed {
      logic [1:0] idx;
      logic       last;
   } beat_t;

   logic  clk;
   logic  rst_n;
   int    checks;
   int    errors;
   beat_t exp_q [$];

   arbiter_iwrr_burst_sched_if #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(WW), .P_LEN_W(LW)) bus ();

   arbiter_iwrr_burst_sched #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(WW), .P_LEN_W(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Monitor: every fire on the shared channel must match the next expected beat.
   always @(negedge clk) begin
      beat_t      b;
      logic [3:0] oh;
      if (rst_n && bus.m_valid_o && bus.m_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got idx %0d last %0d, required no beat",
                     bus.grant_idx_o, bus.m_last_o);
         end else begin
            b  = exp_q.pop_front();
            oh = 4'b0001 << b.idx;
            if (bus.grant_idx_o !== b.idx || bus.m_last_o !== b.last ||
                bus.grant_valid_o !== oh || bus.s_ready_o !== oh) begin
               errors++;
               $display("FAIL beat: got idx %0d last %0d grant %b s_ready %b, required idx %0d last %0d grant %b s_ready %b",
                        bus.grant_idx_o, bus.m_last_o, bus.grant_valid_o, bus.s_ready_o,
                        b.idx, b.last, oh, oh);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic push(input logic [1:0] idx, input logic last);
      beat_t b;
      b.idx  = idx;
      b.last = last;
      exp_q.push_back(b);
   endtask

   task automatic drain(input string name, input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_grant_valid"}, 32'(bus.grant_valid_o), 32'd0);
      check({name, "_grant_idx"},   32'(bus.grant_idx_o),   32'd0);
      check({name, "_busy"},        32'(bus.busy_o),        32'd0);
      check({name, "_m_valid"},     32'(bus.m_valid_o),     32'd0);
      check({name, "_s_ready"},     32'(bus.s_ready_o),     32'd0);
      check({name, "_m_last"},      32'(bus.m_last_o),      32'd0);
   endtask

   task automatic apply_reset(input string name);
      rst_n            = 1'b0;
      bus.req_i        = 4'b0000;
      bus.req_len_i    = 32'd0;
      bus.req_weight_i = 16'd0;
      bus.s_valid_i    = 4'b0000;
      bus.m_ready_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero(name);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] pat;
      checks = 0;
      errors = 0;

      // 1: weights {2,1,1,1}, everyone requesting single-beat bursts
      apply_reset("t1_reset");
      bus.req_weight_i = {4'd1, 4'd1, 4'd1, 4'd2};
      bus.s_valid_i    = 4'b1111;
      bus.m_ready_i    = 1'b1;
      push(2'd0, 1'b1); push(2'd1, 1'b1); push(2'd2, 1'b1); push(2'd3, 1'b1); push(2'd0, 1'b1);
      push(2'd1, 1'b1); push(2'd2, 1'b1); push(2'd3, 1'b1); push(2'd0, 1'b1); push(2'd0, 1'b1);
      bus.req_i = 4'b1111;
      drain("t1", 60);
      bus.req_i = 4'b0000;
      repeat (3) @(posedge clk);
      #1;

      // 2: single requester 1, len 3, m_ready stalls 1,0,1,0,1,1
      apply_reset("t2_reset");
      bus.req_weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
      bus.req_len_i    = 32'h0000_0300;
      bus.s_valid_i    = 4'b1111;
      bus.m_ready_i    = 1'b1;
      push(2'd1, 1'b0); push(2'd1, 1'b0); push(2'd1, 1'b0); push(2'd1, 1'b1);
      bus.req_i = 4'b0010;
      @(posedge clk); #1;
      check("t2_reload_busy", 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;
      check("t2_grant_busy", 32'(bus.busy_o), 32'd1);
      check("t2_grant_idx", 32'(bus.grant_idx_o), 32'd1);
      bus.req_i = 4'b0000;
      pat = 6'b110101;
      for (int k = 0; k < 6; k++) begin
         bus.m_ready_i = pat[k];
         #1;
         check("t2_grant_held", 32'(bus.grant_valid_o), 32'b0010);
         check("t2_m_last", 32'(bus.m_last_o), (k == 5) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      check("t2_busy_drop", 32'(bus.busy_o), 32'd0);
      check("t2_grant_drop", 32'(bus.grant_valid_o), 32'd0);
      bus.m_ready_i = 1'b1;
      drain("t2", 10);

      // 3: requester 2, len 3, s_valid gaps 1,0,0,1,1,1
      apply_reset("t3_reset");
      bus.req_weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
      bus.req_len_i    = 32'h0003_0000;
      bus.m_ready_i    = 1'b1;
      push(2'd2, 1'b0); push(2'd2, 1'b0); push(2'd2, 1'b0); push(2'd2, 1'b1);
      bus.req_i = 4'b0100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t3_grant_busy", 32'(bus.busy_o), 32'd1);
      bus.req_i = 4'b0000;
      pat = 6'b111001;
      for (int k = 0; k < 6; k++) begin
         bus.s_valid_i = {1'b0, pat[k], 2'b00};
         #1;
         check("t3_m_valid", 32'(bus.m_valid_o), 32'(pat[k]));
         @(posedge clk); #1;
      end
      check("t3_busy_drop", 32'(bus.busy_o), 32'd0);
      bus.s_valid_i = 4'b1111;
      drain("t3", 10);

      // 4: weights {1,1,0,1}: requester 2 excluded
      apply_reset("t4_reset");
      bus.req_weight_i = {4'd1, 4'd0, 4'd1, 4'd1};
      bus.s_valid_i    = 4'b1111;
      bus.m_ready_i    = 1'b1;
      push(2'd0, 1'b1); push(2'd1, 1'b1); push(2'd3, 1'b1);
      push(2'd0, 1'b1); push(2'd1, 1'b1); push(2'd3, 1'b1);
      bus.req_i = 4'b1111;
      drain("t4", 40);
      bus.req_i = 4'b0000;
      @(posedge clk); #1;
      bus.req_i = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("t4_zero_wt_busy", 32'(bus.busy_o), 32'd0);
         check("t4_zero_wt_grant", 32'(bus.grant_valid_o), 32'd0);
      end
      bus.req_i = 4'b0000;

      // 5: asynchronous reset in the middle of a burst (cnt = 2)
      apply_reset("t5_reset");
      bus.req_weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
      bus.req_len_i    = 32'h0000_0002;
      bus.s_valid_i    = 4'b1111;
      bus.m_ready_i    = 1'b0;
      bus.req_i        = 4'b0001;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5_pre_busy", 32'(bus.busy_o), 32'd1);
      check("t5_pre_m_valid", 32'(bus.m_valid_o), 32'd1);
      check("t5_pre_m_last", 32'(bus.m_last_o), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("t5_async");
      rst_n         = 1'b1;
      bus.m_ready_i = 1'b1;
      push(2'd0, 1'b0); push(2'd0, 1'b0); push(2'd0, 1'b1);
      @(posedge clk); #1;
      check("t5_post_reload_busy", 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;
      check("t5_post_grant", 32'(bus.grant_valid_o), 32'b0001);
      bus.req_i = 4'b0000;
      drain("t5", 10);

      // 6: requester 1 drops and its length changes mid-burst; ptr resumes after 1
      apply_reset("t6_reset");
      bus.req_weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
      bus.req_len_i    = 32'h0000_0200;
      bus.s_valid_i    = 4'b1111;
      bus.m_ready_i    = 1'b1;
      push(2'd1, 1'b0); push(2'd1, 1'b0); push(2'd1, 1'b1); push(2'd2, 1'b1);
      bus.req_i = 4'b0110;
      @(posedge clk); #1;
      check("t6_reload_busy", 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;
      check("t6_grant1_idx", 32'(bus.grant_idx_o), 32'd1);
      bus.req_i     = 4'b0101;
      bus.req_len_i = 32'h0000_0500;
      @(posedge clk); #1;
      check("t6_busy_b2", 32'(bus.busy_o), 32'd1);
      @(posedge clk); #1;
      check("t6_busy_b3", 32'(bus.busy_o), 32'd1);
      @(posedge clk); #1;
      check("t6_bubble", 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;
      check("t6_grant2", 32'(bus.grant_valid_o), 32'b0100);
      check("t6_grant2_idx", 32'(bus.grant_idx_o), 32'd2);
      bus.req_i = 4'b0000;
      drain("t6", 10);
      repeat (3) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
